// File: rtl/axi4_copy_engine_pkg.sv
// axi4_copy_pkg: shared state encoding and AXI sizing helpers for the copy engine.
package axi4_copy_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP} state_e;
    localparam int AXI_LEN_W = 8;
    function automatic int byte_off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction
endpackage

// File: rtl/axi4_copy_engine_if.sv
// axi4_copy_if: command channel plus AXI4 master-side port of the copy engine.
interface axi4_copy_if
    import axi4_copy_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 6,
    parameter int G_DATA_WIDTH = 32,
    parameter int G_MAX_BEATS  = 16
);
    localparam int LW = $clog2(G_MAX_BEATS);
    logic                    cmd_valid, cmd_ready, done;
    logic [G_ADDR_WIDTH-1:0] cmd_src, cmd_dst;
    logic [LW-1:0]           cmd_len;
    logic                    m_arvalid, m_arready;
    logic [G_ADDR_WIDTH-1:0] m_araddr;
    logic [AXI_LEN_W-1:0]    m_arlen;
    logic                    m_rvalid, m_rready, m_rlast;
    logic [G_DATA_WIDTH-1:0] m_rdata;
    logic                    m_awvalid, m_awready;
    logic [G_ADDR_WIDTH-1:0] m_awaddr;
    logic [AXI_LEN_W-1:0]    m_awlen;
    logic                    m_wvalid, m_wready, m_wlast;
    logic [G_DATA_WIDTH-1:0] m_wdata;
    logic                    m_bvalid, m_bready;
    modport master (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len,
        output cmd_ready, done,
        output m_arvalid, m_araddr, m_arlen, input m_arready,
        input  m_rvalid, m_rdata, m_rlast, output m_rready,
        output m_awvalid, m_awaddr, m_awlen, input m_awready,
        output m_wvalid, m_wdata, m_wlast, input m_wready,
        input  m_bvalid, output m_bready
    );
    modport slave (
        output cmd_valid, cmd_src, cmd_dst, cmd_len,
        input  cmd_ready, done,
        input  m_arvalid, m_araddr, m_arlen, output m_arready,
        output m_rvalid, m_rdata, m_rlast, input m_rready,
        input  m_awvalid, m_awaddr, m_awlen, output m_awready,
        input  m_wvalid, m_wdata, m_wlast, output m_wready,
        output m_bvalid, input m_bready
    );
endinterface

// File: rtl/axi4_copy_engine_buffer.sv
// copy_buffer: word buffer between the read and write bursts; one write port, async read.
module copy_buffer #(
    parameter int G_MAX_BEATS  = 16,
    parameter int G_DATA_WIDTH = 32,
    localparam int LW = $clog2(G_MAX_BEATS)
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [LW-1:0]           waddr,
    input  logic [G_DATA_WIDTH-1:0] wdata,
    input  logic [LW-1:0]           raddr,
    output logic [G_DATA_WIDTH-1:0] rdata
);
    logic [G_DATA_WIDTH-1:0] mem_q [G_MAX_BEATS];
    logic [G_DATA_WIDTH-1:0] mem_d [G_MAX_BEATS];
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end
    always_ff @(posedge clock) mem_q <= mem_d;
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/axi4_copy_engine.sv
// axi4_copy_engine: one read burst into a local buffer, then one write burst out of it,
// strictly serialized to match a one-transaction-at-a-time AXI4 slave.
module axi4_copy_engine
    import axi4_copy_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 6,
    parameter int G_DATA_WIDTH = 32,
    parameter int G_MAX_BEATS  = 16
) (
    input logic        clock,
    input logic        reset,
    axi4_copy_if.master bus
);
    localparam int LW = $clog2(G_MAX_BEATS);
    localparam int OB = byte_off_bits(G_DATA_WIDTH);
    localparam logic [G_ADDR_WIDTH-1:0] ALIGN = {G_ADDR_WIDTH{1'b1}} << OB;
    state_e                  state_q, state_d;
    logic [LW-1:0]           cnt_q, cnt_d, len_q, len_d;
    logic [G_ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [G_DATA_WIDTH-1:0] buf_rdata;
    logic                    last_beat, buf_we, unused_rlast;
    assign last_beat    = cnt_q == len_q;
    assign buf_we       = state_q == S_RDATA && bus.m_rvalid;
    assign unused_rlast = bus.m_rlast;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                src_d   = bus.cmd_src & ALIGN;
                dst_d   = bus.cmd_dst & ALIGN;
                len_d   = bus.cmd_len;
                cnt_d   = '0;
                state_d = S_RADDR;
            end
            S_RADDR: state_d = bus.m_arready ? S_RDATA : S_RADDR;
            S_RDATA: if (bus.m_rvalid) begin
                cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
                state_d = last_beat ? S_WADDR : S_RDATA;
            end
            S_WADDR: state_d = bus.m_awready ? S_WDATA : S_WADDR;
            S_WDATA: if (bus.m_wready) begin
                cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
                state_d = last_beat ? S_WRESP : S_WDATA;
            end
            S_WRESP: state_d = bus.m_bvalid ? S_IDLE : S_WRESP;
            default: state_d = S_IDLE;
        endcase
    end
    // Handshake outputs depend on state only; done is the combinational B acceptance.
    assign bus.cmd_ready = state_q == S_IDLE;
    assign bus.m_arvalid = state_q == S_RADDR;
    assign bus.m_rready  = state_q == S_RDATA;
    assign bus.m_awvalid = state_q == S_WADDR;
    assign bus.m_wvalid  = state_q == S_WDATA;
    assign bus.m_bready  = state_q == S_WRESP;
    assign bus.m_wlast   = state_q == S_WDATA && last_beat;
    assign bus.done      = state_q == S_WRESP && bus.m_bvalid;
    assign bus.m_araddr  = src_q;
    assign bus.m_awaddr  = dst_q;
    assign bus.m_arlen   = AXI_LEN_W'(len_q);
    assign bus.m_awlen   = AXI_LEN_W'(len_q);
    assign bus.m_wdata   = buf_rdata;
    copy_buffer #(.G_MAX_BEATS(G_MAX_BEATS), .G_DATA_WIDTH(G_DATA_WIDTH)) u_buf (
        .clock(clock),
        .we   (buf_we),
        .waddr(cnt_q),
        .wdata(bus.m_rdata),
        .raddr(cnt_q),
        .rdata(buf_rdata)
    );
endmodule

// File: tb/tb_axi4_copy_engine.sv
// tb_axi4_copy_engine: randomly stalling AXI slave RAM plus scoreboard of expected AR/AW/W traffic.
module tb_axi4_copy_engine;
    import axi4_copy_pkg::*;
    localparam int AW = 6, DW = 32, MB = 16;
    logic clock = 1'b0, reset = 1'b1;
    always #5 clock = ~clock;
    axi4_copy_if #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_MAX_BEATS(MB)) bus ();
    axi4_copy_engine #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW), .G_MAX_BEATS(MB)) dut (
        .clock(clock), .reset(reset), .bus(bus.master)
    );
    typedef struct {logic [5:0] addr; logic [7:0] len;} ax_t;
    typedef struct {logic [31:0] data; int word; logic last;} beat_t;
    ax_t   exp_ar[$], exp_aw[$], ea;
    beat_t exp_w[$], eb;
    logic [31:0] ram [16], ref_mem [16];
    int checks = 0, errors = 0, cyc = 0, done_cyc = -10, done_cnt = 0, pending = 0, issued = 0;
    int rd_word, rd_left = 0, rd_beat, wr_word, wr_left = 0, wr_beat;
    logic b_pend = 0, ar_st = 0, aw_st = 0, w_st = 0, w_pl;
    logic [5:0] ar_pa, aw_pa, rs, rd;
    logic [7:0] ar_pl, aw_pl;
    logic [31:0] w_pd;
    logic [3:0] rl;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Slave: drive at negedge, resolve the handshakes of the coming posedge at negedge+1.
    initial begin
        {bus.m_arready, bus.m_rvalid, bus.m_rlast, bus.m_awready, bus.m_wready, bus.m_bvalid} = '0;
        bus.m_rdata = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                {bus.m_arready, bus.m_rvalid, bus.m_rlast, bus.m_awready, bus.m_wready, bus.m_bvalid} = '0;
            end else begin
                bus.m_arready = $urandom_range(0, 2) != 0;
                bus.m_rvalid  = rd_left > 0 && (bus.m_rvalid || $urandom_range(0, 3) != 0);
                bus.m_rdata   = bus.m_rvalid ? ram[(rd_word + rd_beat) & 15] : $urandom;
                bus.m_rlast   = bus.m_rvalid && rd_left == 1;
                bus.m_awready = $urandom_range(0, 2) != 0;
                bus.m_wready  = $urandom_range(0, 2) != 0;
                bus.m_bvalid  = b_pend && (bus.m_bvalid || $urandom_range(0, 2) != 0);
            end
            #1;
            if (reset) begin
                rd_left = 0; wr_left = 0; b_pend = 0; ar_st = 0; aw_st = 0; w_st = 0;
            end else begin
                if (ar_st) check("ar_hold", {bus.m_arvalid, bus.m_araddr, bus.m_arlen}, {1'b1, ar_pa, ar_pl});
                if (aw_st) check("aw_hold", {bus.m_awvalid, bus.m_awaddr, bus.m_awlen}, {1'b1, aw_pa, aw_pl});
                if (w_st) check("w_hold", {bus.m_wvalid, bus.m_wdata, bus.m_wlast}, {1'b1, w_pd, w_pl});
                ar_st = bus.m_arvalid && !bus.m_arready; ar_pa = bus.m_araddr; ar_pl = bus.m_arlen;
                aw_st = bus.m_awvalid && !bus.m_awready; aw_pa = bus.m_awaddr; aw_pl = bus.m_awlen;
                w_st  = bus.m_wvalid && !bus.m_wready;   w_pd  = bus.m_wdata;  w_pl  = bus.m_wlast;
                if (bus.m_arvalid && bus.m_arready) begin
                    if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
                    else begin
                        ea = exp_ar.pop_front();
                        check("araddr", bus.m_araddr, ea.addr);
                        check("arlen", bus.m_arlen, ea.len);
                    end
                    rd_word = int'(bus.m_araddr) >> 2; rd_left = int'(bus.m_arlen) + 1; rd_beat = 0;
                end
                if (bus.m_rvalid && bus.m_rready) begin
                    rd_beat++; rd_left--;
                end
                if (bus.m_awvalid && bus.m_awready) begin
                    if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                    else begin
                        ea = exp_aw.pop_front();
                        check("awaddr", bus.m_awaddr, ea.addr);
                        check("awlen", bus.m_awlen, ea.len);
                    end
                    wr_word = int'(bus.m_awaddr) >> 2; wr_left = int'(bus.m_awlen) + 1; wr_beat = 0;
                end
                if (bus.m_wvalid && bus.m_wready) begin
                    if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        eb = exp_w.pop_front();
                        check("wdata", bus.m_wdata, eb.data);
                        check("wlast", bus.m_wlast, eb.last);
                        check("wword", (wr_word + wr_beat) & 15, eb.word);
                    end
                    ram[(wr_word + wr_beat) & 15] = bus.m_wdata;
                    wr_beat++; wr_left--;
                    if (wr_left == 0) b_pend = 1;
                end
                if (bus.m_bready) begin
                    check("done", bus.done, bus.m_bvalid);
                    if (bus.m_bvalid) begin
                        b_pend = 0; pending--; done_cnt++; done_cyc = cyc;
                    end
                end else if (bus.done) check("done_spurious", bus.done, 0);
            end
        end
    end

    task automatic do_cmd(input logic [5:0] s, input logic [5:0] d, input logic [3:0] l,
                          input bit keep, input bit after_done);
        int n = 0;
        logic [31:0] tmp [16];
        ax_t a;
        beat_t b;
        @(negedge clock);
        bus.cmd_valid = 1; bus.cmd_src = s; bus.cmd_dst = d; bus.cmd_len = l;
        #2;
        while (!bus.cmd_ready && n < 4000) begin
            @(negedge clock); #2; n++;
        end
        if (n >= 4000) begin
            check("cmd_timeout", 0, 1);
            bus.cmd_valid = 0;
            return;
        end
        if (after_done) check("accept_after_done", cyc, done_cyc + 1);
        a.addr = s & 6'h3C; a.len = 8'(l); exp_ar.push_back(a);
        a.addr = d & 6'h3C; exp_aw.push_back(a);
        for (int i = 0; i <= int'(l); i++) tmp[i] = ref_mem[(int'(s) / 4 + i) & 15];
        for (int i = 0; i <= int'(l); i++) begin
            b.data = tmp[i]; b.word = (int'(d) / 4 + i) & 15; b.last = i == int'(l);
            exp_w.push_back(b);
            ref_mem[b.word] = tmp[i];
        end
        pending++; issued++;
        @(negedge clock); #2;
        check("arvalid_after_accept", bus.m_arvalid, 1);
        check("cmd_ready_busy", bus.cmd_ready, 0);
        if (!keep) bus.cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pending != 0 || !bus.cmd_ready) && n < 4000) begin
            @(negedge clock); #2; n++;
        end
        if (n >= 4000) check("idle_timeout", pending, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_valids"}, {bus.m_arvalid, bus.m_rready, bus.m_awvalid, bus.m_wvalid,
                                 bus.m_bready, bus.m_wlast, bus.done}, 0);
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_src = '0; bus.cmd_dst = '0; bus.cmd_len = '0;
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        ram[0] = 32'hDEADBEEF;
        ref_mem = ram;
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        check_idle_outputs("reset");
        @(negedge clock); reset = 0;
        do_cmd(6'h00, 6'h20, 4'd0, 0, 0);
        wait_idle();
        check("t1_word8", ram[8], 32'hDEADBEEF);
        check("t1_done_cnt", done_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            ram[i] = i + 1; ref_mem[i] = i + 1;
        end
        do_cmd(6'h00, 6'h30, 4'd3, 0, 0);
        wait_idle();
        for (int i = 0; i < 4; i++) check("t2_word", ram[12 + i], i + 1);
        do_cmd(6'h03, 6'h10, 4'd1, 0, 0);
        wait_idle();
        check("t3_word4", ram[4], 1);
        check("t3_word5", ram[5], 2);
        do_cmd(6'h00, 6'h28, 4'd1, 1, 0);
        do_cmd(6'h30, 6'h38, 4'd2, 0, 1);
        wait_idle();
        repeat (6) begin
            rs = 6'($urandom); rd = 6'($urandom); rl = 4'($urandom);
            do_cmd(rs, rd, rl, 0, 0);
        end
        wait_idle();
        do_cmd(6'h00, 6'h20, 4'd7, 0, 0);
        for (int n = 0; !bus.m_wvalid && n < 500; n++) begin
            @(negedge clock); #2;
        end
        check("t6_reach_wdata", bus.m_wvalid, 1);
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
        check_idle_outputs("midreset");
        @(negedge clock); reset = 0;
        exp_ar.delete(); exp_aw.delete(); exp_w.delete();
        pending = 0;
        ref_mem = ram;
        do_cmd(6'h08, 6'h00, 4'd4, 0, 0);
        wait_idle();
        for (int i = 0; i < 16; i++) check("final_ram", ram[i], ref_mem[i]);
        check("done_total", done_cnt, issued - 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_copy_engine.md
# axi4_copy_engine

Single-channel AXI4 memory-to-memory copy controller that sequences the on-chip AXI4 full slave RAM. A command (source address, destination address, burst length) starts one read burst into a local word buffer, then one write burst from that buffer. Transactions are strictly serialized (read completes before write starts), matching the slave's one-transaction-at-a-time behaviour. Sits between the host command logic and the slave's master-side port.

## Interface
- G_ADDR_WIDTH, 6, byte address width of the AXI port
- G_DATA_WIDTH, 32, data width; multiple of 8
- G_MAX_BEATS, 16, buffer depth in words; power of two, ≥2; LW = log2(G_MAX_BEATS)
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command accepted when cmd_valid&cmd_ready
- cmd_src  in  G_ADDR_WIDTH  source byte address
- cmd_dst  in  G_ADDR_WIDTH  destination byte address
- cmd_len  in  LW  beats minus one (AXI len encoding)
- done  out  1  one-cycle pulse on write response accepted
- m_arvalid / m_arready  out / in  1  read address handshake
- m_araddr  out  G_ADDR_WIDTH  latched src, low log2(G_DATA_WIDTH/8) bits forced 0
- m_arlen  out  8  latched len, zero-extended
- m_rvalid / m_rready  in / out  1  read data handshake
- m_rdata  in  G_DATA_WIDTH  read data
- m_rlast  in  1  read last (not used for control)
- m_awvalid / m_awready  out / in  1  write address handshake
- m_awaddr  out  G_ADDR_WIDTH  latched dst, low bits forced 0
- m_awlen  out  8  latched len, zero-extended
- m_wvalid / m_wready  out / in  1  write data handshake
- m_wdata  out  G_DATA_WIDTH  buffer word at beat counter
- m_wlast  out  1  high on final write beat
- m_bvalid / m_bready  in / out  1  write response handshake

## Operation
- FSM states: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.
- IDLE: cmd_ready=1; on accept latch src/dst/len, beat counter cnt←0, → RADDR.
- RADDR: m_arvalid=1 held until m_arready; then → RDATA.
- RDATA: m_rready=1; each m_rvalid beat writes m_rdata to buf[cnt], cnt++; beat with cnt==len → WADDR, cnt←0.
- WADDR: m_awvalid=1 held until m_awready; → WDATA.
- WDATA: m_wvalid=1, m_wdata=buf[cnt], m_wlast=(cnt==len); on m_wready cnt++; last beat → WRESP.
- WRESP: m_bready=1; on m_bvalid → IDLE, done=1 that cycle (registered pulse visible next cycle is NOT allowed: done combinational from WRESP&m_bvalid).
- cnt is LW bits; never wraps since len ≤ G_MAX_BEATS-1. m_rlast/bresp ignored.
- Valid outputs are functions of state only; address/len outputs stable while valid high (AXI rule).

## Timing
- Reset: state IDLE, cnt 0; cmd_ready=1, all m_*valid/ready=0, m_wlast=0, done=0 in the cycle after the reset edge. Reset mid-transaction abandons it silently; buffer contents not cleared.
- Accept at cycle N → m_arvalid at N+1. Handshake completing at cycle K → next state's outputs at K+1.
- Command presented while busy: cmd_ready=0, held until IDLE.
- Zero-stall minimum: len+1 read beats + len+1 write beats + 3 address/response cycles plus slave latency.

## Structure
- Package axi4_copy_pkg: state enum typedef, AXI len width (8), helper for byte offset bits.
- Sub-module copy_buffer: G_MAX_BEATS×G_DATA_WIDTH register array, one write port (we, waddr, wdata), one combinational read port.

## Test plan
- Reset, then cmd src=0x00 dst=0x20 len=0 with slave RAM word0=0xDEADBEEF → one read, one write; word8=0xDEADBEEF, done pulses once.
- len=3 from 0x00 (words 1,2,3,4) to 0x30 → words 12..15 = 1,2,3,4; m_wlast only on 4th beat; m_arlen=m_awlen=3.
- Unaligned src=0x03 → m_araddr=0x00 driven.
- cmd_valid held high during copy → second command accepted only cycle after done; both copies correct.
- Random m_rvalid/m_wready/m_bvalid stalls → valid signals never drop before handshake, data unchanged.
- reset asserted in WDATA of a len=7 copy → next cycle all valids 0, cmd_ready=1; new command completes normally.
